operand_fetch: RTL and testbench

Decode-stage read side of the integer register file in the 5-stage RV32 pipeline. The block drives the register file's two combinational read addresses and takes back the two read data words. It bypasses same-cycle writeback data, which the register file does not forward internally. A per-register pending-write scoreboard stalls decode on RAW hazards, and the block registers resolved operands into the ID/EX stage with a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/reg_scoreboard.sv | 80 ++++++++
 rtl/operand_fetch.sv | 93 +++++++++
 tb/tb_operand_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared integer-core constants: data width, register index width and count,
// and the hardwired-zero register index.
package cpu_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;
  localparam logic [REG_AW-1:0] REG_X0 = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters for the decode stage.
// Tracks writes in flight and answers the RAW-hazard and saturation queries.
// Sets a sticky error on a writeback to a register with no pending write.
// Optional feature: OPFETCH_WB_BYPASS_EN. When it is defined, a count of one that
// is being retired this cycle is not treated as a hazard, because the writeback
// bypass in the operand resolve supplies the value.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              use1,
  input  logic [REG_AW-1:0] rs1,
  input  logic              use2,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rd_we,
  input  logic [REG_AW-1:0] rd,
  input  logic              inc,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  output logic              hazard1,
  output logic              hazard2,
  output logic              sat,
  output logic              sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend [NREG];
  logic [NREG-1:0]  inc_vec, dec_vec;
  logic [CNT_W-1:0] p1, p2, pd, pw;
  logic             byp1, byp2, err_now;

  assign p1 = pend[rs1];
  assign p2 = pend[rs2];
  assign pd = pend[rd];
  assign pw = pend[wb_wa];

  // A count of one about to be retired by the writeback is covered by the bypass.
`ifdef OPFETCH_WB_BYPASS_EN
  assign byp1 = (p1 == CNT_ONE) && wb_we && (wb_wa == rs1);
  assign byp2 = (p2 == CNT_ONE) && wb_we && (wb_wa == rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hazard1 = use1 && (rs1 != REG_X0) && (p1 != '0) && !byp1;
  assign hazard2 = use2 && (rs2 != REG_X0) && (p2 != '0) && !byp2;
  // A full counter may still take a new write if one retires in the same cycle.
  assign sat     = rd_we && (rd != REG_X0) && (pd == CNT_MAX) && !(wb_we && (wb_wa == rd));
  assign err_now = wb_we && (wb_wa != REG_X0) && (pw == '0);

  // Decode per-register increment/decrement requests; x0 never counts.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = inc && rd_we && (rd == REG_AW'(r));
      dec_vec[r] = wb_we && (wb_wa == REG_AW'(r)) && (pend[r] != '0);
    end
  end

  // Counter update: simultaneous inc and dec on one register cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      pend[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])      pend[r] <= pend[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r]) pend[r] <= pend[r] - CNT_ONE;
      end
      if (err_now) sb_err <= 1'b1;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Decode-stage register file read side: read addressing, operand resolve,
// RAW-hazard stall via the pending-write scoreboard, and the ID/EX register.
// Optional feature: OPFETCH_WB_BYPASS_EN enables the same-cycle writeback bypass.
// Without it, operands always come from the register file, and a dependent
// instruction waits until its source has no pending write.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic              sb_err
);
  logic            hazard1, hazard2, sat, fire;
  logic [XLEN-1:0] op1, op2;

  assign ra1 = id_rs1;
  assign ra2 = id_rs2;

  reg_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .use1    (id_use_rs1),
    .rs1     (id_rs1),
    .use2    (id_use_rs2),
    .rs2     (id_rs2),
    .rd_we   (id_rd_we),
    .rd      (id_rd),
    .inc     (fire),
    .wb_we   (wb_we),
    .wb_wa   (wb_wa),
    .hazard1 (hazard1),
    .hazard2 (hazard2),
    .sat     (sat),
    .sb_err  (sb_err)
  );

  assign id_ready = !hazard1 && !hazard2 && !sat && (!ex_valid || ex_ready);
  assign fire     = id_valid && id_ready;

  // Operand resolve: x0 reads zero; the register file does not forward its own write.
  always_comb begin
    op1 = rd1;
    op2 = rd2;
`ifdef OPFETCH_WB_BYPASS_EN
    if (wb_we && (wb_wa == id_rs1)) op1 = wb_wd;
    if (wb_we && (wb_wa == id_rs2)) op2 = wb_wd;
`endif
    if (id_rs1 == REG_X0) op1 = '0;
    if (id_rs2 == REG_X0) op2 = '0;
  end

  // ID/EX register: load on fire, drain on ex_ready, hold under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_rd    <= '0;
      ex_rd_we <= 1'b0;
    end else if (fire) begin
      ex_valid <= 1'b1;
      ex_op1   <= op1;
      ex_op2   <= op2;
      ex_rd    <= id_rd;
      ex_rd_we <= id_rd_we;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: the bench plays the register file,
// keeps a behavioural model of the pending counts and ID/EX contents, and
// compares every negedge, plus directed literal expectations per scenario.
module tb_operand_fetch;
  import cpu_pkg::*;

`ifdef OPFETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready, id_use_rs1, id_use_rs2, id_rd_we;
  logic [4:0]  id_rs1, id_rs2, id_rd, ra1, ra2, wb_wa, ex_rd;
  logic [31:0] rd1, rd2, wb_wd, ex_op1, ex_op2;
  logic        wb_we, ex_valid, ex_ready, ex_rd_we, sb_err;

  always #5 clk = ~clk;

  // Register file stand-in; entry 0 holds garbage to prove x0 is forced to zero.
  logic [31:0] rf [32];
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h11;
      rf[0] <= 32'hBAD0BAD0;
    end else if (wb_we && wb_wa != 0) rf[wb_wa] <= wb_wd;
  end

  operand_fetch dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .sb_err(sb_err)
  );

  int tests = 0, fails = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: writes in flight per register, ID/EX contents, sticky error.
  int          m_pend [32];
  logic        m_ev, m_rd_we, m_err;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_rd;

  function automatic bit m_hz(input logic u, input logic [4:0] rs);
    if (!u || rs == 0 || m_pend[rs] == 0) return 1'b0;
    if (BYP && m_pend[rs] == 1 && wb_we && wb_wa == rs) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit s;
    s = id_rd_we && id_rd != 0 && m_pend[id_rd] == 3 && !(wb_we && wb_wa == id_rd);
    return !m_hz(id_use_rs1, id_rs1) && !m_hz(id_use_rs2, id_rs2) && !s && (!m_ev || ex_ready);
  endfunction

  // Architectural value of a source as seen by the issuing instruction.
  function automatic logic [31:0] m_val(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (BYP && wb_we && wb_wa == rs) return wb_wd;
    return rf[rs];
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit fire;
    int np [32];
    if (rst) begin
      for (int i = 0; i < 32; i++) m_pend[i] <= 0;
      m_ev <= 0; m_op1 <= 0; m_op2 <= 0; m_rd <= 0; m_rd_we <= 0; m_err <= 0;
    end else begin
      fire = id_valid && m_ready();
      np = m_pend;
      if (fire && id_rd_we && id_rd != 0) np[id_rd] = np[id_rd] + 1;
      if (wb_we && wb_wa != 0) begin
        if (m_pend[wb_wa] > 0) np[wb_wa] = np[wb_wa] - 1;
        else m_err <= 1'b1;
      end
      m_pend <= np;
      if (fire) begin
        m_ev <= 1'b1; m_op1 <= m_val(id_rs1); m_op2 <= m_val(id_rs2);
        m_rd <= id_rd; m_rd_we <= id_rd_we;
      end else if (ex_ready) m_ev <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_id_ready", 32'(id_ready), 32'(m_ready()));
      check("cmp_ex_valid", 32'(ex_valid), 32'(m_ev));
      check("cmp_sb_err", 32'(sb_err), 32'(m_err));
      check("cmp_ra1", 32'(ra1), 32'(id_rs1));
      if (m_ev) begin
        check("cmp_ex_op1", ex_op1, m_op1);
        check("cmp_ex_op2", ex_op2, m_op2);
        check("cmp_ex_rd", 32'(ex_rd), 32'(m_rd));
        check("cmp_ex_rd_we", 32'(ex_rd_we), 32'(m_rd_we));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd_we = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; wb_we = 0; wb_wa = 0; wb_wd = 0;
  endtask

  initial begin
    idle(); ex_ready = 1; rst = 0;
    #1 rst = 1;
    neg();
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_sb_err", 32'(sb_err), 0);
    step(); rst = 0;

    // Independent issue
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
    neg(); check("indep_ready", 32'(id_ready), 1);
    step(); idle();
    neg(); check("indep_op1", ex_op1, 32'h11); check("indep_op2", ex_op2, 32'h22);

    // RAW on x3, resolved by writeback
    id_valid = 1; id_rd = 3; id_rd_we = 1;
    step();
    id_rd_we = 0; id_rd = 0; id_rs1 = 3; id_use_rs1 = 1;
    neg(); check("raw_stall", 32'(id_ready), 0);
    step();
    wb_we = 1; wb_wa = 3; wb_wd = 32'hDEADBEEF;
    neg(); check("raw_wb_cycle_ready", 32'(id_ready), 32'(BYP));
    step(); wb_we = 0;
    if (!BYP) begin
      neg(); check("raw_late_ready", 32'(id_ready), 1);
      step();
    end
    idle();
    neg(); check("raw_op1", ex_op1, 32'hDEADBEEF); check("raw_ex_valid", 32'(ex_valid), 1);

    // x0 handling
    id_valid = 1; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 2; id_use_rs2 = 1; id_rd = 0; id_rd_we = 1;
    neg(); check("x0_ready", 32'(id_ready), 1);
    step(); idle();
    neg(); check("x0_op1", ex_op1, 0); check("x0_ex_rd_we", 32'(ex_rd_we), 1);
    wb_we = 1; wb_wa = 0; wb_wd = 32'h123;
    step(); wb_we = 0;
    neg(); check("x0_wb_no_err", 32'(sb_err), 0);
    id_valid = 1; id_rd = 0; id_rd_we = 1;
    for (int i = 0; i < 4; i++) begin
      neg(); check("x0_no_count", 32'(id_ready), 1);
      step();
    end
    idle();

    // Saturation on x7
    id_valid = 1; id_rd = 7; id_rd_we = 1;
    for (int i = 0; i < 3; i++) begin
      neg(); check("sat_b2b_ready", 32'(id_ready), 1);
      step();
    end
    neg(); check("sat_stall", 32'(id_ready), 0);
    #1 wb_we = 1; wb_wa = 7; wb_wd = 32'h77;
    #1 check("sat_wb_ready", 32'(id_ready), 1);
    step(); wb_we = 0;
    neg(); check("sat_still_full", 32'(id_ready), 0);
    id_valid = 0; wb_we = 1; wb_wa = 7;
    repeat (3) step();
    idle();

    // Back-pressure
    ex_ready = 0;
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
    step();
    id_rs1 = 4;
    neg(); check("bp_ready", 32'(id_ready), 0); check("bp_op1", ex_op1, 32'h11);
    repeat (2) step();
    neg(); check("bp_hold_op1", ex_op1, 32'h11); check("bp_hold_valid", 32'(ex_valid), 1);
    #1 ex_ready = 1;
    step(); idle();
    neg(); check("bp_next_op1", ex_op1, 32'h44);

    // Writeback with nothing pending
    wb_we = 1; wb_wa = 9; wb_wd = 32'h9;
    step(); wb_we = 0;
    neg(); check("err_set", 32'(sb_err), 1);
    repeat (3) step();
    neg(); check("err_sticky", 32'(sb_err), 1);

    // Reset mid-stream with pend[5]=2, ex_valid=1
    id_valid = 1; id_rd = 5; id_rd_we = 1;
    repeat (2) step();
    idle();
    #2 rst = 1;
    #1;
    check("mrst_ex_valid", 32'(ex_valid), 0); check("mrst_sb_err", 32'(sb_err), 0);
    check("mrst_ex_op1", ex_op1, 0); check("mrst_ex_rd", 32'(ex_rd), 0);
    rst = 0;
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
    neg(); check("mrst_pend_clear", 32'(id_ready), 1);
    step(); idle();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
